sub_seq_64: RTL

Sequential multi-cycle subtractor: the borrow-chain counterpart of the carry look-ahead adder family. It computes A − B − BIN over a WIDTH-bit operand using one SLICE-bit subtract per cycle, carrying the borrow in a register between slices. It sits behind a valid/ready handshake as an area-cheap arithmetic and compare unit where a full-width parallel adder is not justified.

---
 rtl/sub_seq_64.sv | 129 ++++++++++++
 1 files changed

// File: rtl/sub_seq_64.sv
// sub_seq_64: sequential multi-cycle subtractor, diff = a - b - bin.
// One SLICE-bit subtract per cycle with the borrow carried in a register
// between slices; N = WIDTH/SLICE slice cycles per operation.
//
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   in_valid, in_ready     operand handshake (a, b, bin)
//   a, b, bin              minuend, subtrahend, borrow in
//   out_valid, out_ready   result handshake
//   diff                   a - b - bin (mod 2^WIDTH, or saturated)
//   bout                   final borrow (unsigned result negative)
//   zero                   diff == 0
//   ovf                    two's-complement signed overflow
//
// Optional feature macro: SUB_SEQ_SAT_EN -- when defined, a final borrow of 1
// saturates diff to 0 (zero = 1); bout and ovf still reflect the true result.
module sub_seq_64 #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SLICE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int unsigned N  = WIDTH / SLICE;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nx;

  // Operands and result held as N slices so the active slice is a plain index.
  logic [N-1:0][SLICE-1:0] a_r, b_r, work, work_nx;
  logic                    borrow, borrow_nx;
  logic [CW-1:0]           k;
  logic [SLICE:0]          sum;
  logic                    last;
  logic                    sat;
  logic [WIDTH-1:0]        res_nx;
  logic                    ovf_nx;

  // Slice datapath: a + ~b + ~borrow; the carry out is the inverted borrow.
  always_comb begin
    sum       = {1'b0, a_r[k]} + {1'b0, ~b_r[k]} + {{SLICE{1'b0}}, ~borrow};
    work_nx   = work;
    work_nx[k] = sum[SLICE-1:0];
    borrow_nx = ~sum[SLICE];
    last      = (k == CW'(N - 1));
`ifdef SUB_SEQ_SAT_EN
    sat       = borrow_nx;
`else
    sat       = 1'b0;
`endif
    res_nx    = sat ? '0 : work_nx;
    // Overflow always judged on the unsaturated result.
    ovf_nx    = (a_r[N-1][SLICE-1] != b_r[N-1][SLICE-1]) &
                (work_nx[N-1][SLICE-1] != a_r[N-1][SLICE-1]);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      work      <= '0;
      borrow    <= 1'b0;
      k         <= '0;
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r    <= a;
            b_r    <= b;
            borrow <= bin;
            k      <= '0;
          end
        end
        RUN: begin
          work   <= work_nx;
          borrow <= borrow_nx;
          k      <= k + 1'b1;
          // Results load from the final slice's combinational values so they
          // appear on the same edge that enters DONE.
          if (last) begin
            out_valid <= 1'b1;
            diff      <= res_nx;
            bout      <= borrow_nx;
            zero      <= (res_nx == '0);
            ovf       <= ovf_nx;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
